counter: RTL and testbench

COUNTER -- requirements
Module: counter

---
 rtl/counter.sv | 34 +++
 tb/tb_counter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/counter.sv
// Free-running WIDTH-bit up-counter with an active-high count enable.
// An active-low asynchronous reset clears the count; out comes straight off the register.
`timescale 1ns/1ps
module counter #(
  parameter int unsigned WIDTH = 26
) (
  input  logic             resetn,
  input  logic             clk,
  input  logic             en,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Plain unsigned add: all-ones rolls over to zero with no flag and no stall.
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out = count_q;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: directed scenarios followed by random enable, glitch and
// reset traffic, compared against a count of enabled edges reduced modulo 2^WIDTH.
`timescale 1ns/1ps
module tb_counter;

  logic        resetn;
  logic        clk;
  logic        en;
  logic [25:0] out26;
  logic [3:0]  out4;

  int unsigned n_tests;
  int unsigned n_fail;
  longint      cnt;  // enabled edges since the last reset

  counter dut (
    .resetn (resetn),
    .clk    (clk),
    .en     (en),
    .out    (out26)
  );

  counter #(
    .WIDTH (4)
  ) dut4 (
    .resetn (resetn),
    .clk    (clk),
    .en     (en),
    .out    (out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_both(input string tag);
    check({tag, "/w26"}, {6'b0, out26}, 32'(cnt % (64'd1 << 26)));
    check({tag, "/w4"}, {28'b0, out4}, 32'(cnt % 64'd16));
  endtask

  // Advance one rising edge, account for it in the model, sample 1 ns later.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!resetn) cnt = 0;
    else if (en) cnt = cnt + 1;
    #1;
    check_both(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cnt     = 0;
    resetn  = 1'b1;
    en      = 1'b0;

    // Power-up pulse from t=1 to t=3.
    #1 resetn = 1'b0;
    #2;
    cnt = 0;
    check_both("por_clear");
    resetn = 1'b1;
    tick("por_hold_en0");                 // edge t=5, now t=6

    // Enable from t=6: edges t=15..t=155 give 1..15.
    en = 1'b1;
    for (int i = 0; i < 15; i++) tick("count_up");
    // Narrow instance is at all-ones; next two edges give 0 then 1 there.
    tick("wrap_to_0");
    tick("wrap_to_1");

    // Hold: fresh reset, count to 5, disable for 4 edges, re-enable.
    #2 resetn = 1'b0;
    #1;
    cnt = 0;
    check_both("hold_reset");
    #1 resetn = 1'b1;
    for (int i = 0; i < 5; i++) tick("hold_count");
    #1 en = 1'b0;
    for (int i = 0; i < 4; i++) tick("hold_en0");
    #1 en = 1'b1;
    tick("hold_resume");

    // Async reset mid-run at 9.
    #2 resetn = 1'b0;
    #1;
    cnt = 0;
    check_both("midrun_clear");
    #1 resetn = 1'b1;
    for (int i = 0; i < 9; i++) tick("midrun_count");
    #2 resetn = 1'b0;
    #1;
    cnt = 0;
    check_both("midrun_async");
    tick("midrun_held");
    tick("midrun_held");
    #2 resetn = 1'b1;
    tick("recover_first_edge");

    // Glitch: en pulsed high only between edges.
    #1 en = 1'b0;
    tick("glitch_pre");
    #2 en = 1'b1;
    #1;
    check_both("glitch_no_comb");
    #2 en = 1'b0;
    tick("glitch_ignored");

    // Random traffic; each iteration starts 1 ns after an edge.
    for (int i = 0; i < 400; i++) begin
      logic e;
      logic glitch;
      logic do_rst;
      e      = 1'($urandom_range(0, 1));
      glitch = ($urandom_range(0, 3) == 0);
      do_rst = ($urandom_range(0, 29) == 0);
      en = e;
      #2;
      if (glitch) begin
        en = ~e;
        #2;
        en = e;
      end else begin
        #2;
      end
      if (do_rst) begin
        resetn = 1'b0;
        #1;
        cnt = 0;
        check_both("rand_async");
        resetn = 1'b1;
        #1;
      end else begin
        #2;
      end
      tick("rand_edge");
    end

    // Long enabled run to exercise carries beyond the narrow instance.
    #1 en = 1'b1;
    for (int i = 0; i < 300; i++) tick("long_run");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
